// File: rtl/lane_scroller_pkg.sv
// Shared types, default intervals and the lane rotation helper for the lane scroller.
package lane_pkg;

  typedef enum logic [1:0] {
    DIFF_EASY   = 2'd0,
    DIFF_MEDIUM = 2'd1,
    DIFF_HARD   = 2'd2,
    DIFF_INSANE = 2'd3
  } difficulty_t;

  localparam int unsigned DEF_INTERVAL0 = 1000;
  localparam int unsigned DEF_INTERVAL1 = 500;
  localparam int unsigned DEF_INTERVAL2 = 200;
  localparam int unsigned DEF_INTERVAL3 = 100;

  // Widest lane the rotate helper handles; lanes are zero-extended into it.
  localparam int MAX_W = 64;
  localparam int IDX_W = $clog2(MAX_W);

  // Rotate the low `width` bits of `lane` by one cell; dir=1 moves cell k to k+1.
  function automatic logic [MAX_W-1:0] rotate(input logic [MAX_W-1:0] lane, input logic dir,
                                               input int width);
    logic [MAX_W-1:0] res;
    logic [IDX_W-1:0] ki;
    logic [IDX_W-1:0] ni;
    res = '0;
    for (int k = 0; k < MAX_W; k++) begin
      if (k < width) begin
        ki = IDX_W'(k);
        ni = (k + 1 == width) ? '0 : IDX_W'(k + 1);
        if (dir) begin
          res[ni] = lane[ki];
        end else begin
          res[ki] = lane[ni];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/lane_scroller_if.sv
// Control/status bundle between the game FSM (master) and the lane scroller (slave).
interface lane_scroller_if
  import lane_pkg::*;
#(
  parameter int NUM_LANES = 13,
  parameter int WIDTH     = 16
);
  localparam int ROW_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  difficulty_t                  difficulty;
  logic                         run;
  logic                         load_en;
  logic [ROW_W-1:0]             load_lane;
  logic [WIDTH-1:0]             load_data;
  logic [ROW_W-1:0]             frog_row;
  logic [COL_W-1:0]             frog_col;
  logic [NUM_LANES*WIDTH-1:0]   lanes;
  logic                         shift_tick;
  logic                         hit;

  modport master (
    output difficulty, run, load_en, load_lane, load_data, frog_row, frog_col,
    input  lanes, shift_tick, hit
  );

  modport slave (
    input  difficulty, run, load_en, load_lane, load_data, frog_row, frog_col,
    output lanes, shift_tick, hit
  );

endinterface

// File: rtl/lane_scroller_rotator.sv
// One obstacle lane: pattern register, per-lane speed divider, load-over-rotate priority.
module lane_rotator
  import lane_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic             DIR   = 1'b1,
  parameter logic [3:0]       DIV   = 4'd0,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] lane,
  output logic [WIDTH-1:0] lane_next
);

  logic [WIDTH-1:0] lane_q, lane_d, lane_rot;
  logic [3:0]       div_q, div_d;
  logic [MAX_W-1:0] rot_full;

  // Lane contents shifted one cell in this lane's direction.
  always_comb begin
    rot_full = rotate(MAX_W'(lane_q), DIR, WIDTH);
    lane_rot = rot_full[WIDTH-1:0];
  end

  // Next state: a load wins over a rotation landing on the same edge.
  always_comb begin
    lane_d = lane_q;
    div_d  = div_q;
    if (load) begin
      lane_d = load_data;
      div_d  = '0;
    end else if (tick) begin
      if (div_q == DIV) begin
        div_d  = '0;
        lane_d = lane_rot;
      end else begin
        div_d = div_q + 4'd1;
      end
    end
  end

  // State register with synchronous reset to the INIT slice.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lane_q <= INIT;
      div_q  <= '0;
    end else begin
      lane_q <= lane_d;
      div_q  <= div_d;
    end
  end

  assign lane      = lane_q;
  assign lane_next = lane_d;

endmodule

// File: rtl/lane_scroller.sv
// Lane scroller top: base-tick counter, interval mux, load decode and registered collision flag.
// NUM_LANES/WIDTH must match the parameters of the connected lane_scroller_if instance.
module lane_scroller
  import lane_pkg::*;
#(
  parameter int                         NUM_LANES = 13,
  parameter int                         WIDTH     = 16,
  parameter int                         CNT_W     = 16,
  parameter int unsigned                INTERVAL0 = DEF_INTERVAL0,
  parameter int unsigned                INTERVAL1 = DEF_INTERVAL1,
  parameter int unsigned                INTERVAL2 = DEF_INTERVAL2,
  parameter int unsigned                INTERVAL3 = DEF_INTERVAL3,
  parameter logic [NUM_LANES-1:0]       LANE_DIR  = '1,
  parameter logic [4*NUM_LANES-1:0]     LANE_DIV  = '0,
  parameter logic [NUM_LANES*WIDTH-1:0] INIT      = '0
) (
  input logic            clk,
  input logic            reset_n,
  lane_scroller_if.slave bus
);

  localparam int ROW_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CNT_W-1:0]           interval;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       tick;
  logic                       shift_tick_q;
  logic                       hit_q, hit_d;
  logic [NUM_LANES-1:0]       load_hit;
  logic [NUM_LANES*WIDTH-1:0] lanes_q;
  logic [WIDTH-1:0]           lane_next [NUM_LANES];

  // Interval selected by the current difficulty.
  always_comb begin
    interval = CNT_W'(INTERVAL0);
    unique case (bus.difficulty)
      DIFF_EASY:   interval = CNT_W'(INTERVAL0);
      DIFF_MEDIUM: interval = CNT_W'(INTERVAL1);
      DIFF_HARD:   interval = CNT_W'(INTERVAL2);
      DIFF_INSANE: interval = CNT_W'(INTERVAL3);
    endcase
  end

  // Base counter; >= so a switch to a shorter interval wraps on the next enabled cycle.
  always_comb begin
    tick  = bus.run && (cnt_q >= interval - CNT_W'(1));
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = '0;
    end else if (bus.run) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Load decode; an out-of-range lane index matches no lane.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      load_hit[i] = bus.load_en && (bus.load_lane == ROW_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_rotator #(
      .WIDTH (WIDTH),
      .DIR   (LANE_DIR[g]),
      .DIV   (LANE_DIV[4*g +: 4]),
      .INIT  (INIT[g*WIDTH +: WIDTH])
    ) u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick),
      .load      (load_hit[g]),
      .load_data (bus.load_data),
      .lane      (lanes_q[g*WIDTH +: WIDTH]),
      .lane_next (lane_next[g])
    );
  end

  // Collision looks at the post-edge lane contents so loads and rotations show immediately.
  always_comb begin
    hit_d = 1'b0;
    if (({1'b0, bus.frog_row} < (ROW_W + 1)'(NUM_LANES)) &&
        ({1'b0, bus.frog_col} < (COL_W + 1)'(WIDTH))) begin
      hit_d = lane_next[bus.frog_row][bus.frog_col];
    end
  end

  // Counter, tick pulse and collision registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      shift_tick_q <= 1'b0;
      hit_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shift_tick_q <= tick;
      hit_q        <= hit_d;
    end
  end

  assign bus.lanes      = lanes_q;
  assign bus.shift_tick = shift_tick_q;
  assign bus.hit        = hit_q;

endmodule

// File: tb/tb_lane_scroller.sv
// Directed bench for lane_scroller with a tick-count lane model and per-cycle comparison.
module tb_lane_scroller;
  import lane_pkg::*;

  localparam int NL = 13;
  localparam int W  = 16;
  localparam logic [NL-1:0]   DIR_P = 13'h1FF5;   // lanes 1 and 3 rotate right
  localparam logic [4*NL-1:0] DIV_P = 52'h1020;   // lane 1 every 3 ticks, lane 3 every 2

  function automatic logic [15:0] init_lane(input int i);
    case (i)
      0, 1:    return 16'h0008;
      2:       return 16'h0003;
      5:       return 16'h0001;
      default: return 16'(i * 257);
    endcase
  endfunction

  function automatic logic [NL*W-1:0] make_init();
    logic [NL*W-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++) r[i*W +: W] = init_lane(i);
    return r;
  endfunction

  localparam logic [NL*W-1:0] INIT_P = make_init();

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lane_scroller_if #(.NUM_LANES(NL), .WIDTH(W)) bus ();

  lane_scroller #(
    .NUM_LANES (NL),
    .WIDTH     (W),
    .CNT_W     (16),
    .INTERVAL0 (1000),
    .INTERVAL1 (500),
    .INTERVAL2 (200),
    .INTERVAL3 (100),
    .LANE_DIR  (DIR_P),
    .LANE_DIV  (DIV_P),
    .INIT      (INIT_P)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [NL*W-1:0] act, input logic [NL*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: lane i shifts on every (DIV+1)-th base tick counted since reset or its last load.
  logic [15:0] m_lane [NL];
  int          m_tcnt [NL];
  int          m_cnt = 0;
  bit          m_tick = 1'b0;
  bit          m_hit = 1'b0;

  function automatic int ival_of(input int d);
    case (d)
      0:       return 1000;
      1:       return 500;
      2:       return 200;
      default: return 100;
    endcase
  endfunction

  function automatic logic [15:0] step(input logic [15:0] x, input bit left);
    if (left) return 16'((x << 1) | (x >> 15));
    return 16'((x >> 1) | (x << 15));
  endfunction

  function automatic logic [NL*W-1:0] m_flat();
    logic [NL*W-1:0] r;
    for (int i = 0; i < NL; i++) r[i*W +: W] = m_lane[i];
    return r;
  endfunction

  always @(posedge clk) begin : model
    logic [15:0] nxt [NL];
    bit tk;
    int iv, r, c, per;
    if (!reset_n) begin
      m_cnt  <= 0;
      m_tick <= 1'b0;
      m_hit  <= 1'b0;
      for (int i = 0; i < NL; i++) begin
        m_lane[i] <= init_lane(i);
        m_tcnt[i] <= 0;
      end
    end else begin
      iv = ival_of(int'(bus.difficulty));
      tk = bus.run && (m_cnt >= iv - 1);
      m_cnt  <= !bus.run ? m_cnt : (tk ? 0 : m_cnt + 1);
      m_tick <= tk;
      for (int i = 0; i < NL; i++) begin
        nxt[i] = m_lane[i];
        per = int'(DIV_P[4*i +: 4]) + 1;
        if (bus.load_en && int'(bus.load_lane) == i) begin
          nxt[i] = bus.load_data;
          m_tcnt[i] <= 0;
        end else if (tk) begin
          m_tcnt[i] <= m_tcnt[i] + 1;
          if ((m_tcnt[i] + 1) % per == 0) nxt[i] = step(m_lane[i], DIR_P[i]);
        end
        m_lane[i] <= nxt[i];
      end
      r = int'(bus.frog_row);
      c = int'(bus.frog_col);
      m_hit <= (r < NL && c < W) ? nxt[r][c] : 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("lanes", bus.lanes, m_flat());
      check("shift_tick", {207'd0, bus.shift_tick}, {207'd0, m_tick});
      check("hit", {207'd0, bus.hit}, {207'd0, m_hit});
    end
  end

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.shift_tick && n < 2000);
  endtask

  task automatic lane_is(input string name, input int idx, input logic [15:0] exp);
    logic [NL*W-1:0] v;
    v = bus.lanes;
    check(name, {192'd0, v[idx*W +: W]}, {192'd0, exp});
  endtask

  initial begin
    int n, ticks;
    logic [NL*W-1:0] snap;
    bus.difficulty = DIFF_INSANE;
    bus.run        = 1'b1;
    bus.load_en    = 1'b0;
    bus.load_lane  = '0;
    bus.load_data  = '0;
    bus.frog_row   = 4'd13;
    bus.frog_col   = 4'd0;
    reset_n        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_lanes", bus.lanes, INIT_P);
    check("reset_hit", {207'd0, bus.hit}, '0);
    check("reset_tick", {207'd0, bus.shift_tick}, '0);

    // Base period and per-lane direction/divider.
    reset_n = 1'b1;
    wait_tick(n);
    check("first_tick_latency", n, 100);
    lane_is("t1_lane0", 0, 16'h0010);
    lane_is("t1_lane1", 1, 16'h0008);
    wait_tick(n);
    check("period", n, 100);
    wait_tick(n);
    lane_is("t3_lane0", 0, 16'h0040);
    lane_is("t3_lane1", 1, 16'h0004);

    // Wrap of the MSB into bit 0.
    bus.load_en = 1'b1; bus.load_lane = 4'd0; bus.load_data = 16'h8000;
    @(negedge clk);
    bus.load_en = 1'b0;
    lane_is("load_lane0", 0, 16'h8000);
    wait_tick(n);
    lane_is("wrap_lane0", 0, 16'h0001);

    // Collision on the frog cell.
    bus.load_en = 1'b1; bus.load_lane = 4'd5; bus.load_data = 16'h0001;
    bus.frog_row = 4'd5; bus.frog_col = 4'd0;
    @(negedge clk);
    bus.load_en = 1'b0;
    check("hit_5_0", {207'd0, bus.hit}, {207'd0, 1'b1});
    bus.frog_col = 4'd1;
    @(negedge clk);
    check("hit_5_1_before", {207'd0, bus.hit}, '0);
    wait_tick(n);
    check("hit_5_1_on_rotate", {207'd0, bus.hit}, {207'd0, 1'b1});
    bus.frog_row = 4'd13;
    @(negedge clk);
    check("hit_row13", {207'd0, bus.hit}, '0);

    // Load lands on the same edge as a tick.
    repeat (98) @(negedge clk);
    bus.load_en = 1'b1; bus.load_lane = 4'd2; bus.load_data = 16'hA5A5;
    @(negedge clk);
    bus.load_en = 1'b0;
    check("load_tick_pulse", {207'd0, bus.shift_tick}, {207'd0, 1'b1});
    lane_is("load_beats_rotate", 2, 16'hA5A5);
    lane_is("other_lane0_rotates", 0, 16'h0004);
    lane_is("other_lane1_rotates", 1, 16'h0002);

    // Difficulty drop mid-count.
    bus.difficulty = DIFF_EASY;
    repeat (700) @(negedge clk);
    bus.difficulty = DIFF_INSANE;
    @(negedge clk);
    check("diff_change_tick", {207'd0, bus.shift_tick}, {207'd0, 1'b1});
    wait_tick(n);
    check("diff_change_period", n, 100);

    // Pause at cnt=40.
    repeat (40) @(negedge clk);
    bus.run = 1'b0;
    snap = m_flat();
    ticks = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.shift_tick) ticks++;
    end
    check("pause_lanes_held", bus.lanes, snap);
    check("pause_no_tick", ticks, 0);
    bus.run = 1'b1;
    wait_tick(n);
    check("resume_latency", n, 60);

    // Reset mid-interval with a load pending.
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    bus.load_en = 1'b1; bus.load_lane = 4'd0; bus.load_data = 16'hFFFF;
    @(negedge clk);
    bus.load_en = 1'b0;
    check("midreset_lanes", bus.lanes, INIT_P);
    check("midreset_hit", {207'd0, bus.hit}, '0);
    reset_n = 1'b1;
    wait_tick(n);
    check("midreset_first_tick", n, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
